// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter.
//   alu_op_t    : two-bit ALU operation code (ADD/SUB/MUL/DIV)
//   arb_state_t : arbiter FSM state encoding
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_RESULT = 2'd2,
        ST_RETURN      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin winner selection.
//   valid   in  2 : per-requester request valid
//   pointer in  1 : requester that wins when both are valid
//   grant   out 2 : one-hot winner, zero when nobody is valid
module rr_picker (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto a single shared ALU, one transaction in flight.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   i_req_valid / o_req_ready     : per-requester request handshake (2 bits)
//   i_req_a, i_req_b              : operands, requester k in [k*DATA_WIDTH +: DATA_WIDTH]
//   i_req_op, i_req_signed        : op (2 bits per requester) and signed flag
//   o_rsp_result, o_rsp_error     : shared response data
//   o_rsp_valid / i_rsp_ready     : per-requester response handshake
//   o_alu_input_*                 : operands/op/signed/valid towards the ALU
//   i_alu_input_ready             : ALU accepts the operands
//   i_alu_result, i_alu_error     : ALU result data
//   i_alu_result_valid / o_alu_result_ready : ALU result handshake
//
// Build option: define ALU_ARB_TIMEOUT_EN to add a WAIT_RESULT watchdog of
// TIMEOUT_CYCLES cycles. A timed-out transaction returns error with result 0
// and leaves a sticky stale flag that drains the late ALU result before any
// new request is granted.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | grant round-robin winner, latch its request on handshake
// ISSUE       | present latched operands to the ALU until accepted
// WAIT_RESULT | accept the ALU result (or time out when enabled)
// RETURN      | hold the response to the granted requester until taken
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              i_req_valid,
    output logic [1:0]              o_req_ready,
    input  logic [2*DATA_WIDTH-1:0] i_req_a,
    input  logic [2*DATA_WIDTH-1:0] i_req_b,
    input  logic [3:0]              i_req_op,
    input  logic [1:0]              i_req_signed,
    output logic [DATA_WIDTH-1:0]   o_rsp_result,
    output logic                    o_rsp_error,
    output logic [1:0]              o_rsp_valid,
    input  logic [1:0]              i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_alu_input_a,
    output logic [DATA_WIDTH-1:0]   o_alu_input_b,
    output logic [1:0]              o_alu_input_op,
    output logic                    o_alu_input_signed,
    output logic                    o_alu_input_valid,
    input  logic                    i_alu_input_ready,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic                    i_alu_error,
    input  logic                    i_alu_result_valid,
    output logic                    o_alu_result_ready
);

    arb_state_t            state_q, state_d;
    logic                  ptr_q;
    logic                  gnt_id_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
    alu_op_t               op_q;
    logic                  sgn_q, err_q;

    logic [1:0] pick_grant;
    logic       accept, result_hs, rsp_done;
    logic       stale, timeout_hit;

    rr_picker u_rr_picker (
        .valid   (i_req_valid),
        .pointer (ptr_q),
        .grant   (pick_grant)
    );

    // Out-of-range timeout settings elaborate this empty marker block.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unsupported
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             stale_q;

    assign stale       = stale_q;
    // Down-counter is loaded on entry to WAIT_RESULT, so terminal count is
    // reached on the TIMEOUT_CYCLES-th waiting cycle.
    assign timeout_hit = (state_q == ST_WAIT_RESULT) && !i_alu_result_valid &&
                         (tmo_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            stale_q   <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE && i_alu_input_ready) begin
                tmo_cnt_q <= TMO_LOAD;
            end else if (state_q == ST_WAIT_RESULT && tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
            end
            // Stale can only be set from WAIT_RESULT and is only cleared
            // outside it, so the two never collide.
            if (timeout_hit) begin
                stale_q <= 1'b1;
            end else if (stale_q && i_alu_result_valid) begin
                stale_q <= 1'b0;
            end
        end
    end
`else
    assign stale       = 1'b0;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        o_req_ready = 2'b00;
        accept      = 1'b0;
        result_hs   = 1'b0;
        rsp_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stale) begin
                    o_req_ready = pick_grant;
                    if (pick_grant != 2'b00) begin
                        accept  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (i_alu_input_ready) begin
                    state_d = ST_WAIT_RESULT;
                end
            end
            ST_WAIT_RESULT: begin
                if (i_alu_result_valid) begin
                    result_hs = 1'b1;
                    state_d   = ST_RETURN;
                end else if (timeout_hit) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (i_rsp_ready[gnt_id_q]) begin
                    rsp_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            gnt_id_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ALU_ADD;
            sgn_q    <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_id_q <= pick_grant[1];
                a_q      <= pick_grant[1] ? i_req_a[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : i_req_a[DATA_WIDTH-1:0];
                b_q      <= pick_grant[1] ? i_req_b[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : i_req_b[DATA_WIDTH-1:0];
                op_q     <= alu_op_t'(pick_grant[1] ? i_req_op[3:2] : i_req_op[1:0]);
                sgn_q    <= pick_grant[1] ? i_req_signed[1] : i_req_signed[0];
            end
            if (result_hs) begin
                res_q <= i_alu_result;
                err_q <= i_alu_error;
            end else if (timeout_hit) begin
                res_q <= '0;
                err_q <= 1'b1;
            end
            if (rsp_done) begin
                ptr_q <= ~gnt_id_q;
            end
        end
    end

    assign o_alu_input_a      = a_q;
    assign o_alu_input_b      = b_q;
    assign o_alu_input_op     = op_q;
    assign o_alu_input_signed = sgn_q;
    assign o_alu_input_valid  = (state_q == ST_ISSUE);
    // While stale, keep draining so the late ALU result cannot block the ALU.
    assign o_alu_result_ready = (state_q == ST_WAIT_RESULT) || stale;
    assign o_rsp_valid        = (state_q == ST_RETURN) ? {gnt_id_q, ~gnt_id_q} : 2'b00;
    assign o_rsp_result       = res_q;
    assign o_rsp_error        = err_q;

endmodule
